// File: rtl/memarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memarb_pkg
// Description : Shared types and constants for the memory request arbiter.
//               FSM state encoding, requester IDs, transfer length codes
//               (bytes-1), and a helper that builds the mask for a load of a
//               given length.
// Revision    : 1.0 - initial release
// ============================================================================
package memarb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_LD = 3'd2,
    BUSY_ST = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_LD = 2'd1,
    REQ_ST = 2'd2
  } req_e;

  // Length codes carried on the len buses (number of bytes minus one).
  localparam logic [2:0] LEN_B = 3'd0;
  localparam logic [2:0] LEN_H = 3'd1;
  localparam logic [2:0] LEN_W = 3'd3;

  // Bytes above the transfer length are returned as zero.
  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      LEN_B:   return 32'h0000_00FF;
      LEN_H:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memarb_pick.sv
`default_nettype none
// ============================================================================
// Module      : memarb_pick
// Description : Combinational winner select for the memory arbiter.
//               Normal order is ST > LD > IF. A flush blocks IF for the
//               cycle. When the starve flag is raised and IF is grantable,
//               IF wins outright.
// Ports       : if_req_i/ld_req_i/st_req_i - raw requests
//               flush_i  - branch flush, IF not grantable this cycle
//               starve_i - IF has been passed over too often
//               valid_o  - some requester is grantable
//               id_o     - winning requester (meaningful when valid_o)
// Revision    : 1.0 - initial release
// ============================================================================
module memarb_pick
  import memarb_pkg::*;
(
  input  logic if_req_i,
  input  logic ld_req_i,
  input  logic st_req_i,
  input  logic flush_i,
  input  logic starve_i,
  output logic valid_o,
  output req_e id_o
);

  logic w_if_ok;

  assign w_if_ok = if_req_i & ~flush_i;

  always_comb begin
    valid_o = 1'b1;
    id_o    = REQ_IF;
    if (starve_i && w_if_ok) begin
      id_o = REQ_IF;
    end else if (st_req_i) begin
      id_o = REQ_ST;
    end else if (ld_req_i) begin
      id_o = REQ_LD;
    end else if (w_if_ok) begin
      id_o = REQ_IF;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Sequences a shared byte-serial memory controller between
//               instruction fetch (IF), load (LD) and store (ST) requesters.
//               The winner's request is latched and held on the mc_* bus
//               until the matching done; the result is returned with a
//               one-cycle done pulse while the FSM spends one DRAIN cycle
//               with the bus idle. IF results are suppressed after a flush.
// Config      : MEMARB_STARVE_GUARD_EN - when defined, a saturating counter
//               forces an IF grant after STARVE_LIMIT consecutive LD/ST
//               grants taken while IF was waiting. Undefined: strict
//               ST > LD > IF priority, no counter.
// Ports       : clk_in, rst_in (sync, active high), rdy_in (0 = freeze),
//               flush_in; IF/LD/ST request side (if_*, ld_*, st_*);
//               memctrl side (mc_read/write/ifetch/addr/wdata/len out,
//               mc_mem_done/if_done/rdata/instr in).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEMARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_instr,
  // load unit
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  // store unit
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [31:0]       st_data,
  output logic              st_done,
  // memory controller
  output logic              mc_read,
  output logic              mc_write,
  output logic              mc_ifetch,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
  output logic [2:0]        mc_len,
  input  logic              mc_mem_done,
  input  logic              mc_if_done,
  input  logic [31:0]       mc_rdata,
  input  logic [31:0]       mc_instr
);

  state_e            state_q;
  logic              cancel_q;
  logic              mc_read_q;
  logic              mc_write_q;
  logic              mc_ifetch_q;
  logic [ADDR_W-1:0] mc_addr_q;
  logic [31:0]       mc_wdata_q;
  logic [2:0]        mc_len_q;
  logic              if_done_q;
  logic [31:0]       if_instr_q;
  logic              ld_done_q;
  logic [31:0]       ld_data_q;
  logic              st_done_q;

  logic              w_pick_valid;
  req_e              w_pick_id;
  logic              w_starve;
  logic              w_grant;

  memarb_pick u_pick (
    .if_req_i (if_req),
    .ld_req_i (ld_req),
    .st_req_i (st_req),
    .flush_i  (flush_in),
    .starve_i (w_starve),
    .valid_o  (w_pick_valid),
    .id_o     (w_pick_id)
  );

  assign w_grant = (state_q == IDLE) & w_pick_valid;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  assign w_starve = (starve_cnt_q >= CNT_MAX);

  // Counts LD/ST grants taken while IF was waiting; a flushed cycle does not
  // count because IF could not have been granted then anyway.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt_q <= '0;
    end else if (rdy_in) begin
      if (!if_req) begin
        starve_cnt_q <= '0;
      end else if (w_grant && (w_pick_id == REQ_IF)) begin
        starve_cnt_q <= '0;
      end else if (w_grant && !flush_in && (starve_cnt_q != CNT_MAX)) begin
        starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign w_starve = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cancel_q    <= 1'b0;
      mc_read_q   <= 1'b0;
      mc_write_q  <= 1'b0;
      mc_ifetch_q <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      mc_len_q    <= '0;
      if_done_q   <= 1'b0;
      if_instr_q  <= '0;
      ld_done_q   <= 1'b0;
      ld_data_q   <= '0;
      st_done_q   <= 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          cancel_q <= 1'b0;
          if (w_pick_valid) begin
            case (w_pick_id)
              REQ_ST: begin
                mc_write_q <= 1'b1;
                mc_addr_q  <= st_addr;
                mc_len_q   <= st_len;
                mc_wdata_q <= st_data;
                state_q    <= BUSY_ST;
              end
              REQ_LD: begin
                mc_read_q  <= 1'b1;
                mc_addr_q  <= ld_addr;
                mc_len_q   <= ld_len;
                mc_wdata_q <= '0;
                state_q    <= BUSY_LD;
              end
              default: begin
                mc_ifetch_q <= 1'b1;
                mc_addr_q   <= if_addr;
                mc_len_q    <= LEN_W;
                mc_wdata_q  <= '0;
                state_q     <= BUSY_IF;
              end
            endcase
          end
        end

        BUSY_IF: begin
          // The fetch cannot be aborted mid-transfer in memctrl, so a flush
          // only marks the result as unwanted.
          if (flush_in) begin
            cancel_q <= 1'b1;
          end
          if (mc_if_done) begin
            mc_ifetch_q <= 1'b0;
            mc_addr_q   <= '0;
            mc_len_q    <= '0;
            state_q     <= DRAIN;
            if (!cancel_q && !flush_in) begin
              if_done_q  <= 1'b1;
              if_instr_q <= mc_instr;
            end
          end
        end

        BUSY_LD: begin
          if (mc_mem_done) begin
            mc_read_q <= 1'b0;
            mc_addr_q <= '0;
            mc_len_q  <= '0;
            ld_done_q <= 1'b1;
            ld_data_q <= mc_rdata & len_mask(mc_len_q);
            state_q   <= DRAIN;
          end
        end

        BUSY_ST: begin
          if (mc_mem_done) begin
            mc_write_q <= 1'b0;
            mc_addr_q  <= '0;
            mc_len_q   <= '0;
            mc_wdata_q <= '0;
            st_done_q  <= 1'b1;
            state_q    <= DRAIN;
          end
        end

        DRAIN: begin
          // One idle bus cycle lets memctrl clear its byte counters.
          if_done_q <= 1'b0;
          ld_done_q <= 1'b0;
          st_done_q <= 1'b0;
          cancel_q  <= 1'b0;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mc_read   = mc_read_q;
  assign mc_write  = mc_write_q;
  assign mc_ifetch = mc_ifetch_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;
  assign mc_len    = mc_len_q;
  assign if_done   = if_done_q;
  assign if_instr  = if_instr_q;
  assign ld_done   = ld_done_q;
  assign ld_data   = ld_data_q;
  assign st_done   = st_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Self-checking bench for mem_req_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios
//               add literal expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [2:0]  ld_len, st_len;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_instr, ld_data;
  logic        mc_read, mc_write, mc_ifetch;
  logic [31:0] mc_addr, mc_wdata;
  logic [2:0]  mc_len;
  logic        mc_mem_done, mc_if_done;
  logic [31:0] mc_rdata, mc_instr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int SL = 2;
  mem_req_arbiter #(.ADDR_W(32), .STARVE_LIMIT(SL)) dut (
`else
  mem_req_arbiter #(.ADDR_W(32)) dut (
`endif
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
    .mc_read(mc_read), .mc_write(mc_write), .mc_ifetch(mc_ifetch), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_len(mc_len), .mc_mem_done(mc_mem_done), .mc_if_done(mc_if_done),
    .mc_rdata(mc_rdata), .mc_instr(mc_instr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_phase: 0 no transaction, 1 transaction open on the bus, 2 result just returned
  // m_owner: 1 IF, 2 LD, 3 ST
  bit          m_on = 1'b0;
  int          m_phase, m_owner, m_starve;
  bit          m_cancel;
  logic        e_read, e_write, e_ifetch, e_ifd, e_ldd, e_std;
  logic [31:0] e_addr, e_wdata, e_instr, e_ldata;
  logic [2:0]  e_len;
  bit          k_mc, k_instr, k_ldata;

  task automatic model_step();
    int w;
    bit if_ok;
    bit hit;
    logic [31:0] mask;
    if (rst_in) begin
      m_on = 1'b1; m_phase = 0; m_owner = 0; m_cancel = 1'b0; m_starve = 0;
      e_read = 0; e_write = 0; e_ifetch = 0; e_ifd = 0; e_ldd = 0; e_std = 0;
      e_addr = 0; e_wdata = 0; e_len = 0; e_instr = 0; e_ldata = 0;
      k_mc = 1'b1; k_instr = 1'b1; k_ldata = 1'b1;
      return;
    end
    if (!m_on || !rdy_in) return;
    w = 0;
    if_ok = if_req && !flush_in;
    case (m_phase)
      0: begin
`ifdef MEMARB_STARVE_GUARD_EN
        if (if_ok && m_starve >= SL) w = 1; else
`endif
        if (st_req) w = 3;
        else if (ld_req) w = 2;
        else if (if_ok) w = 1;
        if (w != 0) begin
          m_owner = w; m_phase = 1; m_cancel = 1'b0;
          e_ifetch = (w == 1); e_read = (w == 2); e_write = (w == 3);
          e_addr  = (w == 1) ? if_addr : (w == 2) ? ld_addr : st_addr;
          e_len   = (w == 1) ? 3'd3 : (w == 2) ? ld_len : st_len;
          e_wdata = (w == 3) ? st_data : 32'd0;
          k_mc = 1'b1;
        end
      end
      1: begin
        if (m_owner == 1 && flush_in) m_cancel = 1'b1;
        hit = (m_owner == 1) ? mc_if_done : mc_mem_done;
        if (hit) begin
          e_read = 0; e_write = 0; e_ifetch = 0; k_mc = 1'b0; m_phase = 2;
          if (m_owner == 1) begin
            if (!m_cancel) begin e_ifd = 1; e_instr = mc_instr; k_instr = 1'b1; end
            else k_instr = 1'b0;
          end else if (m_owner == 2) begin
            mask = (e_len >= 3) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (e_len + 1))) - 32'd1);
            e_ldd = 1; e_ldata = mc_rdata & mask; k_ldata = 1'b1;
          end else begin
            e_std = 1;
          end
        end
      end
      default: begin
        e_ifd = 0; e_ldd = 0; e_std = 0; m_phase = 0; m_owner = 0;
      end
    endcase
`ifdef MEMARB_STARVE_GUARD_EN
    if (!if_req) m_starve = 0;
    else if (w == 1) m_starve = 0;
    else if (w >= 2 && !flush_in && m_starve < SL) m_starve++;
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process ----------------
  int  n_ifp = 0, n_ldp = 0, n_stp = 0;
  bit  p_if = 0, p_ld = 0, p_st = 0;

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      check("mc_read",   mc_read,   e_read);
      check("mc_write",  mc_write,  e_write);
      check("mc_ifetch", mc_ifetch, e_ifetch);
      check("if_done",   if_done,   e_ifd);
      check("ld_done",   ld_done,   e_ldd);
      check("st_done",   st_done,   e_std);
      if (k_mc) begin
        check("mc_addr",  mc_addr,  e_addr);
        check("mc_len",   mc_len,   e_len);
        check("mc_wdata", mc_wdata, e_wdata);
      end
      if (k_instr) check("if_instr", if_instr, e_instr);
      if (k_ldata) check("ld_data",  ld_data,  e_ldata);
      if (if_done && !p_if) n_ifp++;
      if (ld_done && !p_ld) n_ldp++;
      if (st_done && !p_st) n_stp++;
      p_if = if_done; p_ld = ld_done; p_st = st_done;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 10; i++) begin
      if (mc_read || mc_write || mc_ifetch) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_busy: got no grant expected a grant within 10 cycles");
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; flush_in = 0;
    if_req = 0; ld_req = 0; st_req = 0;
    if_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0; ld_len = 0; st_len = 0;
    mc_mem_done = 0; mc_if_done = 0; mc_rdata = 0; mc_instr = 0;
    tick(); tick();
    rst_in = 0;
    check("rst_flags", {26'd0, mc_read, mc_write, mc_ifetch, if_done, ld_done, st_done}, 32'd0);
    check("rst_data", if_instr | ld_data | mc_addr | mc_wdata, 32'd0);

    // 1: single fetch
    if_req = 1; if_addr = 32'h100;
    tick();
    check("s1_ifetch", mc_ifetch, 1);
    check("s1_addr", mc_addr, 32'h100);
    tick(); tick();
    mc_if_done = 1; mc_instr = 32'h00A0_0093;
    tick();
    check("s1_if_done", if_done, 1);
    check("s1_instr", if_instr, 32'h00A0_0093);
    check("s1_mc_low", {29'd0, mc_read, mc_write, mc_ifetch}, 0);
    if_req = 0; mc_if_done = 0; mc_instr = 0;
    tick();
    check("s1_done_end", if_done, 0);
    tick();

    // 2: ST > LD > IF with drain gaps
    st_req = 1; st_addr = 32'h2000; st_len = 3; st_data = 32'h1122_3344;
    ld_req = 1; ld_addr = 32'h3000; ld_len = 1;
    if_req = 1; if_addr = 32'h200;
    tick();
    check("s2_write", mc_write, 1);
    check("s2_len", mc_len, 3);
    check("s2_wdata", mc_wdata, 32'h1122_3344);
    mc_mem_done = 1;
    tick();
    check("s2_st_done", st_done, 1);
    check("s2_gap1", {29'd0, mc_read, mc_write, mc_ifetch}, 0);
    st_req = 0; mc_mem_done = 0;
    tick();
    check("s2_gap2", {29'd0, mc_read, mc_write, mc_ifetch}, 0);
    tick();
    check("s2_read", mc_read, 1);
    check("s2_ld_addr", mc_addr, 32'h3000);
    mc_mem_done = 1; mc_rdata = 32'hCAFE_1234;
    tick();
    check("s2_ld_data", ld_data, 32'h0000_1234);
    ld_req = 0; mc_mem_done = 0;
    tick(); tick();
    check("s2_ifetch", mc_ifetch, 1);
    mc_if_done = 1; mc_instr = 32'h0000_0013;
    tick();
    check("s2_if_done", if_done, 1);
    if_req = 0; mc_if_done = 0;
    tick(); tick();

    // 3: flush during fetch, pending load follows
    if_req = 1; if_addr = 32'h400;
    tick();
    check("s3_ifetch", mc_ifetch, 1);
    ld_req = 1; ld_addr = 32'h500; ld_len = 3; flush_in = 1;
    tick();
    flush_in = 0; if_req = 0;
    tick(); tick();
    mc_if_done = 1; mc_instr = 32'hDEAD_BEEF;
    tick();
    check("s3_no_if_done", if_done, 0);
    mc_if_done = 0;
    tick();
    check("s3_idle", mc_read, 0);
    tick();
    check("s3_read", mc_read, 1);
    check("s3_addr", mc_addr, 32'h500);
    mc_mem_done = 1; mc_rdata = 32'h5566_7788;
    tick();
    check("s3_ld_data", ld_data, 32'h5566_7788);
    ld_req = 0; mc_mem_done = 0;
    tick(); tick();

    // 4: byte load, stray fetch-done ignored
    ld_req = 1; ld_addr = 32'h3_0000; ld_len = 0;
    tick();
    check("s4_len", mc_len, 0);
    mc_if_done = 1;
    tick();
    check("s4_ignored", {30'd0, ld_done, mc_read}, 32'd1);
    mc_if_done = 0; mc_mem_done = 1; mc_rdata = 32'h0000_0041;
    tick();
    check("s4_ld_data", ld_data, 32'h0000_0041);
    ld_req = 0; mc_mem_done = 0;
    tick();
    check("s4_one_pulse", ld_done, 0);
    tick();

    // rdy_in low stretches the done pulse
    st_req = 1; st_addr = 32'h40; st_len = 0; st_data = 32'hAB;
    tick();
    mc_mem_done = 1;
    tick();
    st_req = 0; mc_mem_done = 0; rdy_in = 0;
    tick(); tick();
    check("rdy_hold", st_done, 1);
    rdy_in = 1;
    tick();
    check("rdy_release", st_done, 0);
    tick();

    // 5: loads held with a fetch waiting
    if_req = 1; if_addr = 32'h600;
    ld_req = 1; ld_addr = 32'h700; ld_len = 3;
    for (int k = 0; k < 4; k++) begin
      wait_busy();
`ifdef MEMARB_STARVE_GUARD_EN
      check("s5_grant_if", mc_ifetch, (k == 2) ? 32'd1 : 32'd0);
`else
      check("s5_grant_if", mc_ifetch, 0);
`endif
      if (mc_ifetch) mc_if_done = 1; else mc_mem_done = 1;
      tick();
      mc_if_done = 0; mc_mem_done = 0;
      tick();
    end
    if_req = 0; ld_req = 0;
    tick(); tick();

    // 6: reset in the middle of a store
    st_req = 1; st_addr = 32'h80; st_len = 1; st_data = 32'h1234;
    tick();
    check("s6_write", mc_write, 1);
    rst_in = 1;
    tick();
    check("s6_flags", {26'd0, mc_read, mc_write, mc_ifetch, if_done, ld_done, st_done}, 0);
    check("s6_data", if_instr | ld_data | mc_addr | mc_wdata, 0);
    rst_in = 0; st_req = 0; mc_mem_done = 1;
    tick();
    mc_mem_done = 0;
    tick();
    check("s6_no_st_done", st_done, 0);
    tick();

    check("cnt_st_done", n_stp, 2);
`ifdef MEMARB_STARVE_GUARD_EN
    check("cnt_ld_done", n_ldp, 6);
    check("cnt_if_done", n_ifp, 3);
`else
    check("cnt_ld_done", n_ldp, 7);
    check("cnt_if_done", n_ifp, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
